// File: rtl/game_turn_controller.sv
// Turn sequencer for a two-player tic-tac-toe game.
// Owns the board driving an external combinational winner detector.
// Arbitrates X/O move requests and declares win, draw or turn timeout.
module game_turn_controller #(
    parameter int unsigned MOVE_TIMEOUT = 1000,
    parameter int unsigned CNT_W        = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             x_req,
    input  logic [3:0]       x_pos,
    input  logic             o_req,
    input  logic [3:0]       o_pos,
    input  logic             winner_in,
    input  logic [1:0]       who_in,
    output logic [1:0]       pos1,
    output logic [1:0]       pos2,
    output logic [1:0]       pos3,
    output logic [1:0]       pos4,
    output logic [1:0]       pos5,
    output logic [1:0]       pos6,
    output logic [1:0]       pos7,
    output logic [1:0]       pos8,
    output logic [1:0]       pos9,
    output logic             x_ack,
    output logic             o_ack,
    output logic             illegal,
    output logic             timeout,
    output logic [1:0]       turn,
    output logic [3:0]       move_count,
    output logic             game_over,
    output logic [1:0]       result
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_MOVE,
        CHECK,
        GAME_OVER
    } state_t;

    localparam logic [1:0] P_NONE = 2'b00;
    localparam logic [1:0] P_X    = 2'b01;
    localparam logic [1:0] P_O    = 2'b10;
    localparam logic [1:0] R_DRAW = 2'b11;
    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(MOVE_TIMEOUT - 1);

    state_t           state, state_nx;
    logic [1:0]       board    [9];
    logic [1:0]       board_nx [9];
    logic [1:0]       turn_nx;
    logic [3:0]       mc_nx;
    logic [1:0]       result_nx;
    logic             go_nx;
    logic [CNT_W-1:0] timer, timer_nx;
    logic             x_ack_nx, o_ack_nx, illegal_nx, timeout_nx;

    logic             req_v;
    logic [3:0]       req_pos;
    logic             cell_free;

    assign pos1 = board[0];
    assign pos2 = board[1];
    assign pos3 = board[2];
    assign pos4 = board[3];
    assign pos5 = board[4];
    assign pos6 = board[5];
    assign pos7 = board[6];
    assign pos8 = board[7];
    assign pos9 = board[8];

    // Select the on-turn requester and test its target cell for legality
    always_comb begin
        req_v     = 1'b0;
        req_pos   = '0;
        cell_free = 1'b0;
        if (turn == P_X) begin
            req_v   = x_req;
            req_pos = x_pos;
        end else if (turn == P_O) begin
            req_v   = o_req;
            req_pos = o_pos;
        end
        // Positions 0 and 10..15 never match, so they fall out as illegal
        for (int unsigned i = 0; i < 9; i++) begin
            if (req_pos == 4'(i + 1)) begin
                cell_free = (board[i] == P_NONE);
            end
        end
    end

    // Next-state and next-output logic; start overrides everything else
    always_comb begin
        state_nx   = state;
        board_nx   = board;
        turn_nx    = turn;
        mc_nx      = move_count;
        result_nx  = result;
        go_nx      = game_over;
        timer_nx   = timer;
        x_ack_nx   = 1'b0;
        o_ack_nx   = 1'b0;
        illegal_nx = 1'b0;
        timeout_nx = 1'b0;

        if (start) begin
            for (int unsigned i = 0; i < 9; i++) begin
                board_nx[i] = P_NONE;
            end
            mc_nx     = '0;
            result_nx = P_NONE;
            go_nx     = 1'b0;
            turn_nx   = P_X;
            timer_nx  = '0;
            state_nx  = WAIT_MOVE;
        end else begin
            case (state)
                WAIT_MOVE: begin
                    if (req_v && cell_free) begin
                        for (int unsigned i = 0; i < 9; i++) begin
                            if (req_pos == 4'(i + 1)) begin
                                board_nx[i] = turn;
                            end
                        end
                        mc_nx    = move_count + 4'd1;
                        x_ack_nx = (turn == P_X);
                        o_ack_nx = (turn == P_O);
                        timer_nx = '0;
                        state_nx = CHECK;
                    end else begin
                        // A rejected move still lets the turn clock run down
                        illegal_nx = req_v;
                        if (timer == TIMER_LAST) begin
                            timeout_nx = 1'b1;
                            turn_nx    = (turn == P_X) ? P_O : P_X;
                            timer_nx   = '0;
                        end else begin
                            timer_nx = timer + 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (winner_in) begin
                        result_nx = who_in;
                        go_nx     = 1'b1;
                        turn_nx   = P_NONE;
                        state_nx  = GAME_OVER;
                    end else if (move_count == 4'd9) begin
                        result_nx = R_DRAW;
                        go_nx     = 1'b1;
                        turn_nx   = P_NONE;
                        state_nx  = GAME_OVER;
                    end else begin
                        turn_nx  = (turn == P_X) ? P_O : P_X;
                        timer_nx = '0;
                        state_nx = WAIT_MOVE;
                    end
                end
                default: ;
            endcase
        end
    end

    // State, board and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            for (int unsigned i = 0; i < 9; i++) begin
                board[i] <= P_NONE;
            end
            turn       <= P_NONE;
            move_count <= '0;
            result     <= P_NONE;
            game_over  <= 1'b0;
            timer      <= '0;
            x_ack      <= 1'b0;
            o_ack      <= 1'b0;
            illegal    <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_nx;
            board      <= board_nx;
            turn       <= turn_nx;
            move_count <= mc_nx;
            result     <= result_nx;
            game_over  <= go_nx;
            timer      <= timer_nx;
            x_ack      <= x_ack_nx;
            o_ack      <= o_ack_nx;
            illegal    <= illegal_nx;
            timeout    <= timeout_nx;
        end
    end

endmodule

// File: tb/tb_game_turn_controller.sv
// Self-checking bench for game_turn_controller: directed scenarios followed
// by random play, all checked against a game-rules reference model.
module tb_game_turn_controller;

    localparam int TO = 8;
    localparam int LN [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                                 '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       x_req = 1'b0;
    logic [3:0] x_pos = '0;
    logic       o_req = 1'b0;
    logic [3:0] o_pos = '0;
    logic       winner_in;
    logic [1:0] who_in;
    logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
    logic       x_ack, o_ack, illegal, timeout, game_over;
    logic [1:0] turn, result;
    logic [3:0] move_count;

    int passed = 0;
    int total  = 0;
    string cur_tag = "reset";

    // Reference model state
    logic [1:0] mb [9];
    int m_turn, m_mc, m_res, m_go, m_timer, m_phase; // phase: 0 idle, 1 play, 2 judge, 3 over
    int m_xack, m_oack, m_ill, m_to;

    game_turn_controller #(.MOVE_TIMEOUT(TO), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .x_req(x_req), .x_pos(x_pos), .o_req(o_req), .o_pos(o_pos),
        .winner_in(winner_in), .who_in(who_in),
        .pos1(pos1), .pos2(pos2), .pos3(pos3), .pos4(pos4), .pos5(pos5),
        .pos6(pos6), .pos7(pos7), .pos8(pos8), .pos9(pos9),
        .x_ack(x_ack), .o_ack(o_ack), .illegal(illegal), .timeout(timeout),
        .turn(turn), .move_count(move_count), .game_over(game_over), .result(result)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] line_owner(input logic [1:0] b [9]);
        for (int l = 0; l < 8; l++) begin
            if (b[LN[l][0]] != 2'b00 && b[LN[l][0]] == b[LN[l][1]] && b[LN[l][0]] == b[LN[l][2]])
                return b[LN[l][0]];
        end
        return 2'b00;
    endfunction

    // Behavioural winner detector fed from the board outputs
    logic [1:0] cells [9];
    logic [1:0] owner;
    always_comb begin
        cells[0] = pos1; cells[1] = pos2; cells[2] = pos3;
        cells[3] = pos4; cells[4] = pos5; cells[5] = pos6;
        cells[6] = pos7; cells[7] = pos8; cells[8] = pos9;
        owner     = line_owner(cells);
        winner_in = (owner != 2'b00);
        who_in    = owner;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 9; i++) mb[i] = 2'b00;
        m_turn = 0; m_mc = 0; m_res = 0; m_go = 0; m_timer = 0; m_phase = 0;
        m_xack = 0; m_oack = 0; m_ill = 0; m_to = 0;
    endtask

    task automatic model_edge(input bit s, input bit xr, input int xp, input bit orq, input int op);
        bit rq;
        int p;
        bit acc;
        logic [1:0] w;
        m_xack = 0; m_oack = 0; m_ill = 0; m_to = 0;
        if (s) begin
            for (int i = 0; i < 9; i++) mb[i] = 2'b00;
            m_mc = 0; m_res = 0; m_go = 0; m_turn = 1; m_timer = 0; m_phase = 1;
        end else if (m_phase == 1) begin
            rq  = (m_turn == 1) ? xr : orq;
            p   = (m_turn == 1) ? xp : op;
            acc = 0;
            if (rq) begin
                if (p >= 1 && p <= 9 && mb[p-1] == 2'b00) begin
                    mb[p-1] = 2'(m_turn);
                    m_mc++;
                    if (m_turn == 1) m_xack = 1; else m_oack = 1;
                    m_phase = 2;
                    acc = 1;
                end else begin
                    m_ill = 1;
                end
            end
            if (!acc) begin
                if (m_timer == TO - 1) begin
                    m_to = 1; m_turn = 3 - m_turn; m_timer = 0;
                end else begin
                    m_timer++;
                end
            end
        end else if (m_phase == 2) begin
            w = line_owner(mb);
            if (w != 2'b00) begin
                m_res = w; m_go = 1; m_turn = 0; m_phase = 3;
            end else if (m_mc == 9) begin
                m_res = 3; m_go = 1; m_turn = 0; m_phase = 3;
            end else begin
                m_turn = 3 - m_turn; m_timer = 0; m_phase = 1;
            end
        end
    endtask

    task automatic check_all();
        chk({cur_tag, ".board"}, {14'd0, pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1},
            {14'd0, mb[8], mb[7], mb[6], mb[5], mb[4], mb[3], mb[2], mb[1], mb[0]});
        chk({cur_tag, ".turn"}, turn, m_turn);
        chk({cur_tag, ".move_count"}, move_count, m_mc);
        chk({cur_tag, ".game_over"}, game_over, m_go);
        chk({cur_tag, ".result"}, result, m_res);
        chk({cur_tag, ".pulses"}, {x_ack, o_ack, illegal, timeout}, {m_xack[0], m_oack[0], m_ill[0], m_to[0]});
    endtask

    task automatic step(input bit s, input bit xr, input int xp, input bit orq, input int op);
        start = s; x_req = xr; x_pos = 4'(xp); o_req = orq; o_pos = 4'(op);
        @(posedge clk);
        model_edge(s, xr, xp, orq, op);
        #1;
        check_all();
    endtask

    task automatic idle(); step(0, 0, 0, 0, 0); endtask
    task automatic xmove(input int p); step(0, 1, p, 0, 0); idle(); endtask
    task automatic omove(input int p); step(0, 0, 0, 1, p); idle(); endtask

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        cur_tag = "reset";
        check_all();
        chk("reset.turn_const", turn, 2'b00);
        @(negedge clk) rst_n = 1'b1;

        // Requests in IDLE are ignored
        cur_tag = "idle";
        step(0, 1, 5, 1, 6);
        step(0, 1, 1, 0, 0);

        // X wins along the top row
        cur_tag = "t1";
        step(1, 0, 0, 0, 0);
        chk("t1.turn_after_start", turn, 2'b01);
        step(0, 1, 1, 0, 0);
        chk("t1.x_ack_n1", x_ack, 1'b1);
        idle();
        omove(4); xmove(2); omove(5);
        step(0, 1, 3, 0, 0);
        idle();
        chk("t1.result_const", result, 2'b01);
        chk("t1.game_over_const", game_over, 1'b1);
        chk("t1.move_count_const", move_count, 4'd5);
        step(0, 1, 7, 1, 8); // ignored in GAME_OVER

        // Full board, no line
        cur_tag = "t2";
        step(1, 0, 0, 0, 0);
        xmove(1); omove(2); xmove(3); omove(5); xmove(4); omove(6); xmove(8); omove(7);
        xmove(9);
        chk("t2.result_const", result, 2'b11);
        chk("t2.move_count_const", move_count, 4'd9);

        // Illegal requests on O's turn; X repeating its cell is off-turn
        cur_tag = "t3";
        step(1, 0, 0, 0, 0);
        xmove(1);
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 1);
        chk("t3.illegal_occupied", illegal, 1'b1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 12);
        chk("t3.illegal_pos12", illegal, 1'b1);
        chk("t3.turn_const", turn, 2'b10);

        // Off-turn O request on X's turn
        cur_tag = "t4";
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 5);
        step(0, 0, 0, 1, 6);
        chk("t4.no_pulse", {x_ack, o_ack, illegal}, 3'b000);

        // Timeouts and a legal move on the timeout edge
        cur_tag = "t5";
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < TO; i++) idle();
        chk("t5.timeout_const", timeout, 1'b1);
        chk("t5.turn_o", turn, 2'b10);
        for (int i = 0; i < TO; i++) idle();
        chk("t5.turn_x", turn, 2'b01);
        for (int i = 0; i < TO - 1; i++) idle();
        step(0, 1, 5, 0, 0);
        chk("t5.ack_at_edge", {x_ack, timeout}, 2'b10);
        idle();

        // start mid-game, then reset mid-CHECK
        cur_tag = "t6";
        step(1, 0, 0, 0, 0);
        xmove(5);
        step(1, 0, 0, 1, 1);
        chk("t6.restart_turn", turn, 2'b01);
        step(0, 1, 5, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        cur_tag = "t6.rst";
        check_all();
        @(negedge clk) rst_n = 1'b1;
        idle();

        // Random play
        cur_tag = "rand";
        for (int c = 0; c < 600; c++) begin
            bit s, xr, orq;
            int xp, op;
            s   = (m_phase == 0 || m_phase == 3) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 59) == 0);
            xr  = 1'($urandom_range(0, 1));
            orq = 1'($urandom_range(0, 1));
            xp  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 9));
            op  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 9));
            if ($urandom_range(0, 4) == 0) begin xr = 0; orq = 0; end
            step(s, xr, xp, orq, op);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
